// File: rtl/spr_pkg.sv
// Shared constants and types for the special-register write path.
//   - Register-file indices of the special registers (ZR/SP/LR/PC/CPSR).
//   - Bit positions of N,Z,C,V inside the 4-bit flag vectors; in the CPSR
//     word the flags occupy the top nibble [DATA_W-1:DATA_W-4].
//   - Slot indices of the write sequencer; the enum order is also the
//     issue priority (lowest index wins).
package spr_pkg;

  localparam int ZR_ADDR   = 0;
  localparam int SP_ADDR   = 4;
  localparam int LR_ADDR   = 5;
  localparam int PC_ADDR   = 6;
  localparam int CPSR_ADDR = 7;

  // Positions within the {N,Z,C,V} mask/value vectors.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  localparam int NUM_FLAGS = 4;

  localparam int NUM_SLOTS = 5;

  typedef enum logic [2:0] {
    SLOT_PC   = 3'd0,
    SLOT_CPSR = 3'd1,
    SLOT_LR   = 3'd2,
    SLOT_SP   = 3'd3,
    SLOT_GEN  = 3'd4
  } slot_e;

endpackage

// File: rtl/spr_prio_sel.sv
// Fixed-priority one-hot select plus address/data mux.
//   i_vld   [NUM-1:0]             slot valid bits, index 0 = highest priority
//   i_addr  [NUM-1:0][ADDR_W-1:0] per-slot target address
//   i_data  [NUM-1:0][DATA_W-1:0] per-slot write data
//   o_sel   [NUM-1:0]             one-hot grant (all zero when nothing valid)
//   o_addr  [ADDR_W-1:0]          address of granted slot, 0 when idle
//   o_data  [DATA_W-1:0]          data of granted slot, 0 when idle
module spr_prio_sel #(
  parameter int NUM    = 5,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
) (
  input  logic [NUM-1:0]             i_vld,
  input  logic [NUM-1:0][ADDR_W-1:0] i_addr,
  input  logic [NUM-1:0][DATA_W-1:0] i_data,
  output logic [NUM-1:0]             o_sel,
  output logic [ADDR_W-1:0]          o_addr,
  output logic [DATA_W-1:0]          o_data
);

  // Isolate the lowest set bit: v & -v.
  logic [NUM-1:0] w_sel;
  assign w_sel = i_vld & (~i_vld + NUM'(1));
  assign o_sel = w_sel;

  // AND-OR mux; the one-hot grant makes this equivalent to a priority mux
  // and yields zero when no slot is valid.
  always_comb begin
    o_addr = '0;
    o_data = '0;
    for (int i = 0; i < NUM; i++) begin
      o_addr = o_addr | (i_addr[i] & {ADDR_W{w_sel[i]}});
      o_data = o_data | (i_data[i] & {DATA_W{w_sel[i]}});
    end
  end

endmodule

// File: rtl/spr_write_sequencer.sv
// Serialises same-cycle special-register updates onto the single write port
// of the special-register file.
//   i_clk, i_reset                 clock, synchronous active-high reset
//   o_ready                        requests accepted this cycle when high
//   i_pc_req/i_pc_data             PC update
//   i_lr_req/i_lr_data             LR update
//   i_sp_req/i_sp_data             SP update
//   i_flag_req/_mask/_val          CPSR flag update {N,Z,C,V}
//   i_cpsr_cur                     current CPSR from the register file
//   i_gen_req/_addr/_data          generic write (addr 0 = ZR, dropped)
//   o_wr_en/o_wr_addr/o_wr_data    register-file write port
//   o_pending                      slot occupancy {GEN,SP,LR,CPSR,PC}
module spr_write_sequencer
  import spr_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  output logic              o_ready,
  input  logic              i_pc_req,
  input  logic [DATA_W-1:0] i_pc_data,
  input  logic              i_lr_req,
  input  logic [DATA_W-1:0] i_lr_data,
  input  logic              i_sp_req,
  input  logic [DATA_W-1:0] i_sp_data,
  input  logic              i_flag_req,
  input  logic [3:0]        i_flag_mask,
  input  logic [3:0]        i_flag_val,
  input  logic [DATA_W-1:0] i_cpsr_cur,
  input  logic              i_gen_req,
  input  logic [ADDR_W-1:0] i_gen_addr,
  input  logic [DATA_W-1:0] i_gen_data,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic [4:0]        o_pending
);

  // Slot state, indexed by slot_e (index order = issue priority).
  logic [NUM_SLOTS-1:0]             r_vld;
  logic [NUM_SLOTS-1:0][DATA_W-1:0] r_data;
  logic [ADDR_W-1:0]                r_gen_addr;

  logic [NUM_SLOTS-1:0]             w_sel;
  logic [NUM_SLOTS-1:0]             w_req;
  logic [NUM_SLOTS-1:0][DATA_W-1:0] w_ld_data;
  logic [NUM_SLOTS-1:0][ADDR_W-1:0] w_slot_addr;
  logic                             w_ready;
  logic                             w_gen_hit_cpsr;
  logic [DATA_W-1:0]                w_cpsr_base;
  logic [DATA_W-1:0]                w_cpsr_new;

  // ---------------- issue ----------------
  always_comb begin
    w_slot_addr            = '0;
    w_slot_addr[SLOT_PC]   = ADDR_W'(PC_ADDR);
    w_slot_addr[SLOT_CPSR] = ADDR_W'(CPSR_ADDR);
    w_slot_addr[SLOT_LR]   = ADDR_W'(LR_ADDR);
    w_slot_addr[SLOT_SP]   = ADDR_W'(SP_ADDR);
    w_slot_addr[SLOT_GEN]  = r_gen_addr;
  end

  spr_prio_sel #(
    .NUM    (NUM_SLOTS),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_sel (
    .i_vld  (r_vld),
    .i_addr (w_slot_addr),
    .i_data (r_data),
    .o_sel  (w_sel),
    .o_addr (o_wr_addr),
    .o_data (o_wr_data)
  );

  assign o_wr_en   = |r_vld;
  assign o_pending = r_vld;

  // With at most one slot occupied, that slot is the one issuing this cycle,
  // so accepting a fresh batch can never overwrite a write still waiting.
  assign w_ready = ($countones(r_vld) <= 1);
  assign o_ready = w_ready;

  // ---------------- flag merge ----------------
  // Merge against the newest CPSR value in flight: a queued flag update
  // first, then a queued generic write to CPSR, else the file's copy.
  assign w_gen_hit_cpsr = r_vld[SLOT_GEN] && (r_gen_addr == ADDR_W'(CPSR_ADDR));

  always_comb begin
    if (r_vld[SLOT_CPSR])    w_cpsr_base = r_data[SLOT_CPSR];
    else if (w_gen_hit_cpsr) w_cpsr_base = r_data[SLOT_GEN];
    else                     w_cpsr_base = i_cpsr_cur;
  end

  always_comb begin
    w_cpsr_new = w_cpsr_base;
    for (int f = 0; f < NUM_FLAGS; f++) begin
      if (i_flag_mask[f]) w_cpsr_new[DATA_W-NUM_FLAGS+f] = i_flag_val[f];
    end
  end

  // ---------------- accept ----------------
  // A generic write to ZR is accepted (no backpressure) but never queued.
  always_comb begin
    w_req            = '0;
    w_req[SLOT_PC]   = i_pc_req;
    w_req[SLOT_CPSR] = i_flag_req;
    w_req[SLOT_LR]   = i_lr_req;
    w_req[SLOT_SP]   = i_sp_req;
    w_req[SLOT_GEN]  = i_gen_req && (i_gen_addr != ADDR_W'(ZR_ADDR));
  end

  always_comb begin
    w_ld_data            = '0;
    w_ld_data[SLOT_PC]   = i_pc_data;
    w_ld_data[SLOT_CPSR] = w_cpsr_new;
    w_ld_data[SLOT_LR]   = i_lr_data;
    w_ld_data[SLOT_SP]   = i_sp_data;
    w_ld_data[SLOT_GEN]  = i_gen_data;
  end

  // Load takes precedence over the issue-clear of the same slot.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vld      <= '0;
      r_data     <= '0;
      r_gen_addr <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (w_ready && w_req[i]) begin
          r_vld[i]  <= 1'b1;
          r_data[i] <= w_ld_data[i];
        end else if (w_sel[i]) begin
          r_vld[i]  <= 1'b0;
        end
      end
      if (w_ready && w_req[SLOT_GEN]) r_gen_addr <= i_gen_addr;
    end
  end

endmodule
